fp_to_key_byte: RTL and testbench

FP_TO_KEY_BYTE -- requirements
Module: fp_to_key_byte

---
 rtl/fp_pkg.sv | 17 +
 rtl/key_fifo.sv | 56 +++++
 rtl/fp_to_key_byte.sv | 119 +++++++++++
 tb/tb_fp_to_key_byte.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared single-precision field layout and fixed-point conversion constants
// used by the FP adder and the blocks that consume its results.
package fp_pkg;
  localparam int FP_PRECISION = 32;
  localparam int FP_EXPONENT  = 8;
  localparam int FP_FRACTION  = 23;
  localparam int FP_BIAS      = 127;
  localparam int FX_W         = 32;
  localparam int FX_FRAC_BITS = 24;

  typedef logic [FX_W-1:0] fx_t;

  // Keystream byte derived from the low half of the fixed-point value.
  function automatic logic [7:0] fold_byte(input fx_t fx);
    return fx[7:0] ^ fx[15:8];
  endfunction
endpackage

// File: rtl/key_fifo.sv
// First-word-fall-through FIFO: the head entry is visible on pop_data while
// not empty; a push on a full FIFO is accepted only when a pop frees a slot.
module key_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign pop_ok   = pop & ~empty;
  assign push_ok  = push & (~full | pop_ok);
  assign overflow = push & ~push_ok;
  // Empty reads as zero so stale storage never leaks out after reset.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/fp_to_key_byte.sv
// Converts FP adder results to floor(|x| * 2^24), folds the low 16 bits into a
// keystream byte and buffers the bytes in a small output FIFO.
module fp_to_key_byte
  import fp_pkg::*;
#(
  parameter int PRECISION  = FP_PRECISION,
  parameter int EXPONENT   = FP_EXPONENT,
  parameter int FRACTION   = FP_FRACTION,
  parameter int BIAS       = FP_BIAS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          fp_valid,
  input  logic [PRECISION-1:0]          fp_data,
  input  logic                          key_ready,
  input  logic                          err_clr,
  output logic                          key_valid,
  output logic [7:0]                    key_byte,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          sat_flag,
  output logic                          drop_flag,
  output logic [7:0]                    drop_count
);
  // Handshake: fp_valid is a one-cycle strobe with no backpressure; a key byte
  // transfers on a rising edge where key_valid && key_ready, and key_byte is
  // held stable while key_valid && !key_ready.

  logic [EXPONENT-1:0] exp_f;
  logic [FRACTION:0]   mant;
  logic                unused_sign;
  int                  shift_s;
  fx_t                 fx_c;
  logic                sat_c;

  logic                s1_valid;
  logic [7:0]          s1_byte;
  logic                s1_sat;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_overflow;
  logic                pop;

  assign exp_f       = fp_data[PRECISION-2 -: EXPONENT];
  assign mant        = {1'b1, fp_data[FRACTION-1:0]};
  assign unused_sign = fp_data[PRECISION-1];

  // fx = m * 2^(e - (BIAS-1)); exponents that push m past 32 bits saturate.
  always_comb begin
    shift_s = int'(exp_f) - (BIAS - 1);
    fx_c    = '0;
    sat_c   = 1'b0;
    if (exp_f == '0) begin
      fx_c = '0;
    end else if (int'(exp_f) >= BIAS + 8) begin
      fx_c  = '1;
      sat_c = 1'b1;
    end else if (shift_s >= 0) begin
      fx_c = FX_W'(mant) << shift_s[4:0];
    end else if (-shift_s < FX_FRAC_BITS) begin
      fx_c = FX_W'(mant) >> 5'(-shift_s);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_byte  <= '0;
      s1_sat   <= 1'b0;
    end else begin
      s1_valid <= fp_valid;
      if (fp_valid) begin
        s1_byte <= fold_byte(fx_c);
        s1_sat  <= sat_c;
      end
    end
  end

  assign pop = key_valid & key_ready;

  key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_key_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (s1_valid),
    .push_data (s1_byte),
    .pop       (pop),
    .pop_data  (key_byte),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .overflow  (fifo_overflow),
    .count     (fifo_count)
  );

  assign key_valid = ~fifo_empty;

  // err_clr clears the sticky state, but an event in the same cycle still lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_flag   <= 1'b0;
      drop_flag  <= 1'b0;
      drop_count <= '0;
    end else begin
      sat_flag  <= (sat_flag & ~err_clr) | (s1_valid & s1_sat);
      drop_flag <= (drop_flag & ~err_clr) | fifo_overflow;
      if (fifo_overflow) begin
        if (err_clr)                  drop_count <= 8'd1;
        else if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end else if (err_clr) begin
        drop_count <= '0;
      end
    end
  end

  logic unused_full;
  assign unused_full = fifo_full;
endmodule

// File: tb/tb_fp_to_key_byte.sv
// Self-checking bench for fp_to_key_byte: conversion table, latency, overflow,
// full-FIFO streaming and mid-stream reset, with a byte scoreboard.
module tb_fp_to_key_byte;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fp_valid = 1'b0;
  logic [31:0] fp_data = '0;
  logic        key_ready = 1'b0;
  logic        err_clr = 1'b0;
  logic        key_valid;
  logic [7:0]  key_byte;
  logic [2:0]  fifo_count;
  logic        sat_flag;
  logic        drop_flag;
  logic [7:0]  drop_count;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];

  typedef struct {
    logic [31:0] fp;
    logic [7:0]  kb;
    logic        sat;
  } vec_t;
  vec_t vecs[12];

  fp_to_key_byte #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .fp_valid   (fp_valid),
    .fp_data    (fp_data),
    .key_ready  (key_ready),
    .err_clr    (err_clr),
    .key_valid  (key_valid),
    .key_byte   (key_byte),
    .fifo_count (fifo_count),
    .sat_flag   (sat_flag),
    .drop_flag  (drop_flag),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Independent model: shift the 24-bit mantissa up by e, then down by BIAS-1.
  function automatic logic [7:0] model_byte(input logic [31:0] f);
    logic [191:0] v;
    logic [31:0]  fx;
    int           e;
    e = int'(f[30:23]);
    if (e == 0) fx = '0;
    else if (e >= 135) fx = '1;
    else begin
      v  = 192'({1'b1, f[22:0]}) << e;
      fx = v[157:126];
    end
    return fx[7:0] ^ fx[15:8];
  endfunction

  task automatic send(input logic [31:0] f);
    @(posedge clk); #1;
    fp_valid = 1'b1;
    fp_data  = f;
    err_clr  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      fp_valid = 1'b0;
      err_clr  = 1'b0;
    end
  endtask

  task automatic clear_errs();
    @(posedge clk); #1;
    fp_valid = 1'b0;
    err_clr  = 1'b1;
    @(posedge clk); #1;
    err_clr  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: a transfer happens at the next rising edge when valid && ready.
  always @(negedge clk) begin
    if (reset_n && key_valid && key_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got 0x%0h, expected no output", key_byte);
      end else begin
        check("key_byte", 32'(key_byte), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{32'h3F123456, 8'h62, 1'b0};
    vecs[1]  = '{32'h3F800000, 8'h00, 1'b0};
    vecs[2]  = '{32'h33800000, 8'h01, 1'b0};
    vecs[3]  = '{32'h33000000, 8'h00, 1'b0};
    vecs[4]  = '{32'h43800000, 8'h00, 1'b1};
    vecs[5]  = '{32'h7FC00000, 8'h00, 1'b1};
    vecs[6]  = '{32'hBF123456, 8'h62, 1'b0};
    vecs[7]  = '{32'h00400000, 8'h00, 1'b0};
    vecs[8]  = '{32'h4300FFFF, 8'hFF, 1'b0};
    vecs[9]  = '{32'h43800001, 8'h00, 1'b1};
    vecs[10] = '{32'h33FFFFFF, 8'h01, 1'b0};
    vecs[11] = '{32'h7F800000, 8'h00, 1'b1};

    // Reset state, checked while reset is asserted.
    #1;
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_key_byte", 32'(key_byte), 32'd0);
    check("rst_sat_flag", 32'(sat_flag), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    key_ready = 1'b1;
    idle(2);

    // Latency: driven after edge N, visible after edge N+2.
    send(32'h3F123456);
    exp_q.push_back(8'h62);
    idle(1);
    @(negedge clk);
    check("lat_valid_n1", 32'(key_valid), 32'd0);
    @(negedge clk);
    check("lat_valid_n2", 32'(key_valid), 32'd1);
    check("lat_byte", 32'(key_byte), 32'h62);
    drain("lat_drain");

    // Conversion table, one value at a time with sticky flags cleared first.
    for (int i = 0; i < 12; i++) begin
      clear_errs();
      send(vecs[i].fp);
      exp_q.push_back(vecs[i].kb);
      idle(3);
      @(negedge clk);
      check($sformatf("sat_flag_vec%0d", i), 32'(sat_flag), 32'(vecs[i].sat));
    end
    drain("table_drain");
    clear_errs();
    @(negedge clk);
    check("sat_cleared", 32'(sat_flag), 32'd0);

    // Random values with random gaps, consumer always ready.
    for (int i = 0; i < 24; i++) begin
      logic [31:0] f;
      f = {1'(($urandom_range(0, 1))), 8'($urandom_range(95, 140)), 23'($urandom())};
      @(posedge clk); #1;
      fp_valid = 1'($urandom_range(0, 1));
      fp_data  = f;
      if (fp_valid) exp_q.push_back(model_byte(f));
    end
    idle(1);
    drain("random_drain");

    // Overflow: six strobes into a stalled 4-entry FIFO drop the last two.
    clear_errs();
    key_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      logic [31:0] f;
      f = 32'h3F000000 | (32'(i) << 8) | 32'(i * 16 + 5);
      send(f);
      if (i < 4) exp_q.push_back(model_byte(f));
    end
    idle(4);
    @(negedge clk);
    check("ovf_fifo_count", 32'(fifo_count), 32'd4);
    check("ovf_drop_count", 32'(drop_count), 32'd2);
    check("ovf_drop_flag", 32'(drop_flag), 32'd1);
    check("ovf_head", 32'(key_byte), 32'(exp_q[0]));
    idle(2);
    @(negedge clk);
    check("ovf_head_stable", 32'(key_byte), 32'(exp_q[0]));
    @(posedge clk); #1;
    key_ready = 1'b1;
    drain("ovf_drain");
    check("ovf_empty", 32'(fifo_count), 32'd0);
    clear_errs();
    @(negedge clk);
    check("drop_flag_cleared", 32'(drop_flag), 32'd0);
    check("drop_count_cleared", 32'(drop_count), 32'd0);

    // Full FIFO streaming: push and pop together keep the count at four.
    key_ready = 1'b0;
    for (int k = 0; k < 15; k++) begin
      logic [31:0] f;
      f = 32'h3F000000 | (32'(k) << 8) | 32'(k * 7 + 3);
      @(posedge clk); #1;
      fp_valid  = 1'b1;
      fp_data   = f;
      key_ready = (k >= 5);
      exp_q.push_back(model_byte(f));
      if (k >= 5) begin
        @(negedge clk);
        check($sformatf("stream_count_k%0d", k), 32'(fifo_count), 32'd4);
      end
    end
    idle(1);
    drain("stream_drain");
    check("stream_no_drops", 32'(drop_count), 32'd0);

    // Mid-stream reset discards buffered and in-flight bytes.
    key_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] f;
      f = 32'h3F000000 | 32'(i * 9 + 1);
      send(f);
      exp_q.push_back(model_byte(f));
    end
    idle(3);
    @(negedge clk);
    check("pre_rst_count", 32'(fifo_count), 32'd3);
    send(32'h3F123456);
    @(posedge clk); #1;
    fp_valid = 1'b0;
    reset_n  = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_key_valid", 32'(key_valid), 32'd0);
    check("midrst_fifo_count", 32'(fifo_count), 32'd0);
    check("midrst_key_byte", 32'(key_byte), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    key_ready = 1'b1;
    idle(2);
    @(negedge clk);
    check("post_rst_no_output", 32'(key_valid), 32'd0);
    send(32'h33800000);
    exp_q.push_back(8'h01);
    idle(1);
    @(negedge clk);
    check("post_rst_lat_n1", 32'(key_valid), 32'd0);
    @(negedge clk);
    check("post_rst_lat_n2", 32'(key_valid), 32'd1);
    drain("post_rst_drain");

    idle(2);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
